// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the HI/LO multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start_in;
  logic [1:0]       op_in;
  logic [WIDTH-1:0] data1_in;
  logic [WIDTH-1:0] data2_in;
  logic             busy_out;
  logic             done_out;
  logic             divzero_out;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start_in, op_in, data1_in, data2_in,
    input  busy_out, done_out, divzero_out, hi_out, lo_out
  );

  modport slave (
    input  start_in, op_in, data1_in, data2_in,
    output busy_out, done_out, divzero_out, hi_out, lo_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply / restoring divide unit owning the HI/LO registers.
// One operation step per clock; HI/LO are written only on the completion edge.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic          clk_in,
  input logic          rst_in,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;
  typedef enum logic [1:0] {
    OP_MULTU = 2'd0,
    OP_DIVU  = 2'd1,
    OP_MTHI  = 2'd2,
    OP_MTLO  = 2'd3
  } op_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] work_q;    // product {acc, low} or divide {rem, quotient}
  logic [WIDTH-1:0]   opnd_q;    // latched multiplicand or divisor
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               dz_q;
  logic               dzpend_q;  // divide-by-zero result still to be written

  op_t                op;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_d;
  logic [WIDTH:0]     div_up;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_d;

  // One shift-add multiply step and one restoring divide step from the current work register.
  always_comb begin
    op       = op_t'(bus.op_in);
    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    mul_d    = {mul_sum, work_q[WIDTH-1:1]};
    div_up   = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_ge   = (div_up >= {1'b0, opnd_q});
    // Remainder stays below the divisor, so the difference always fits in WIDTH bits.
    div_diff = div_up[WIDTH-1:0] - opnd_q;
    div_d    = {(div_ge ? div_diff : div_up[WIDTH-1:0]), work_q[WIDTH-2:0], div_ge};
  end

  // Control FSM with registered busy/done/divzero and the HI/LO registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      dzpend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_MUL: begin
          work_q <= mul_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            hi_q    <= mul_d[2*WIDTH-1:WIDTH];
            lo_q    <= mul_d[WIDTH-1:0];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end
        end
        S_DIV: begin
          work_q <= div_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            hi_q    <= div_d[2*WIDTH-1:WIDTH];
            lo_q    <= div_d[WIDTH-1:0];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end
        end
        S_IDLE, S_FIN: begin
          if (dzpend_q) begin
            // Finish the divide-by-zero result first; a request in this cycle is dropped
            // so the pending HI/LO write cannot be lost. FIN then returns to IDLE normally.
            hi_q     <= work_q[WIDTH-1:0];
            lo_q     <= '1;
            done_q   <= 1'b1;
            dzpend_q <= 1'b0;
            state_q  <= S_FIN;
          end else if (bus.start_in) begin
            unique case (op)
              OP_MULTU: begin
                opnd_q  <= bus.data1_in;
                work_q  <= {{WIDTH{1'b0}}, bus.data2_in};
                cnt_q   <= '0;
                dz_q    <= 1'b0;
                busy_q  <= 1'b1;
                state_q <= S_MUL;
              end
              OP_DIVU: begin
                opnd_q <= bus.data2_in;
                work_q <= {{WIDTH{1'b0}}, bus.data1_in};
                cnt_q  <= '0;
                if (bus.data2_in == '0) begin
                  dz_q     <= 1'b1;
                  dzpend_q <= 1'b1;
                  state_q  <= S_FIN;
                end else begin
                  dz_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_DIV;
                end
              end
              OP_MTHI: begin
                hi_q    <= bus.data1_in;
                state_q <= S_IDLE;
              end
              OP_MTLO: begin
                lo_q    <= bus.data1_in;
                state_q <= S_IDLE;
              end
              default: state_q <= S_IDLE;
            endcase
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_out    = busy_q;
  assign bus.done_out    = done_q;
  assign bus.divzero_out = dz_q;
  assign bus.hi_out      = hi_q;
  assign bus.lo_out      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a result scoreboard and immediate-assertion checks.
module tb_muldiv_unit;

  logic clk;
  logic rst;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request for exactly one sampling edge, then scramble the operands.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start_in = 1'b1;
    bus.op_in    = op;
    bus.data1_in = a;
    bus.data2_in = b;
    @(negedge clk);
    bus.start_in = 1'b0;
    bus.op_in    = 2'($urandom);
    bus.data1_in = $urandom;
    bus.data2_in = $urandom;
  endtask

  task automatic push_mul(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    p    = 64'(a) * 64'(b);
    e.hi = p[63:32];
    e.lo = p[31:0];
    e.dz = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_div(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
      e.dz = 1'b1;
    end else begin
      e.hi = a % b;
      e.lo = a / b;
      e.dz = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Called at the negedge after the accepting edge; waits for done, pops and compares.
  task automatic wait_and_check(input string tag, input int exp_lat, input int exp_busy,
                                input int poke_at);
    int   lat;
    int   busy_n;
    exp_t e;
    lat    = 0;
    busy_n = 0;
    for (int i = 1; i <= 100; i++) begin
      if (bus.done_out === 1'b1) begin
        lat = i;
        break;
      end
      if (bus.busy_out === 1'b1) busy_n++;
      if (i == poke_at) begin
        bus.start_in = 1'b1;
        bus.op_in    = 2'd0;
        bus.data1_in = 32'd5;
        bus.data2_in = 32'd5;
      end else begin
        bus.start_in = 1'b0;
      end
      @(negedge clk);
    end
    bus.start_in = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 64'(0), 64'(1));
    end else begin
      e = sb.pop_front();
      check({tag, "_hi"}, 64'(bus.hi_out), 64'(e.hi));
      check({tag, "_lo"}, 64'(bus.lo_out), 64'(e.lo));
      check({tag, "_divzero"}, 64'(bus.divzero_out), 64'(e.dz));
    end
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(bus.done_out), 64'(0));
  endtask

  initial begin
    int done_n;
    rst          = 1'b1;
    bus.start_in = 1'b0;
    bus.op_in    = 2'd0;
    bus.data1_in = '0;
    bus.data2_in = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(bus.busy_out), 64'(0));
    check("reset_done", 64'(bus.done_out), 64'(0));
    check("reset_divzero", 64'(bus.divzero_out), 64'(0));
    check("reset_hi", 64'(bus.hi_out), 64'(0));
    check("reset_lo", 64'(bus.lo_out), 64'(0));
    rst = 1'b0;

    // Asynchronous reset: make HI/LO non-zero, then assert reset between edges.
    issue(2'd2, 32'hAAAA_5555, 32'd0);
    issue(2'd3, 32'h1234_0001, 32'd0);
    check("pre_async_hi", 64'(bus.hi_out), 64'h0000_0000_AAAA_5555);
    #2 rst = 1'b1;
    #1;
    check("async_rst_hi", 64'(bus.hi_out), 64'(0));
    check("async_rst_lo", 64'(bus.lo_out), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // MULTU 7 x 6
    issue(2'd0, 32'd7, 32'd6);
    push_mul(32'd7, 32'd6);
    wait_and_check("mul_7x6", 33, 32, 0);

    // MULTU max x max
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_and_check("mul_max", 33, 32, 0);

    // DIVU 100 / 7
    issue(2'd1, 32'd100, 32'd7);
    push_div(32'd100, 32'd7);
    wait_and_check("div_100_7", 33, 32, 0);

    // DIVU by zero: done two cycles after the accepting edge, never busy
    issue(2'd1, 32'h1234_5678, 32'd0);
    push_div(32'h1234_5678, 32'd0);
    wait_and_check("div_zero", 2, 0, 0);

    // MULTU 3 x 3 clears the sticky divide-by-zero flag
    issue(2'd0, 32'd3, 32'd3);
    push_mul(32'd3, 32'd3);
    wait_and_check("mul_3x3", 33, 32, 0);

    // Large divide with non-trivial remainder
    issue(2'd1, 32'hF000_0001, 32'h0001_0003);
    push_div(32'hF000_0001, 32'h0001_0003);
    wait_and_check("div_large", 33, 32, 0);

    // A start pulse while dividing must be ignored
    issue(2'd1, 32'd100, 32'd7);
    push_div(32'd100, 32'd7);
    wait_and_check("div_ignore_start", 33, 32, 9);

    // MTHI / MTLO: immediate write, no busy or done
    issue(2'd2, 32'hDEAD_BEEF, 32'd0);
    check("mthi_hi", 64'(bus.hi_out), 64'h0000_0000_DEAD_BEEF);
    check("mthi_busy", 64'(bus.busy_out), 64'(0));
    check("mthi_done", 64'(bus.done_out), 64'(0));
    issue(2'd3, 32'h0BAD_F00D, 32'd0);
    check("mtlo_lo", 64'(bus.lo_out), 64'h0000_0000_0BAD_F00D);
    check("mtlo_hi_kept", 64'(bus.hi_out), 64'h0000_0000_DEAD_BEEF);
    check("mtlo_done", 64'(bus.done_out), 64'(0));

    // Reset during cycle 15 of a MULTU aborts it with no done pulse
    issue(2'd0, 32'h0001_2345, 32'h0006_789A);
    repeat (14) @(negedge clk);
    check("mul_abort_busy_before", 64'(bus.busy_out), 64'(1));
    check("mul_abort_hi_held", 64'(bus.hi_out), 64'h0000_0000_DEAD_BEEF);
    #2 rst = 1'b1;
    #1;
    check("mul_abort_busy", 64'(bus.busy_out), 64'(0));
    check("mul_abort_hi", 64'(bus.hi_out), 64'(0));
    check("mul_abort_lo", 64'(bus.lo_out), 64'(0));
    @(negedge clk);
    rst    = 1'b0;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done_out === 1'b1) done_n++;
      @(negedge clk);
    end
    check("mul_abort_no_done", 64'(done_n), 64'(0));
    check("mul_abort_idle", 64'(bus.busy_out), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
